// File: rtl/bioz_afe_dtbpsdm_dwa_controller_pkg.sv
// Shared definitions for the DT bandpass sigma-delta DWA element controller:
// DEM mode encoding, default element count and code-width derivation.
package bioz_afe_dtbpsdm_dwa_controller_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    LP_DWA = 2'b01,
    BP_DWA = 2'b10,
    RSVD   = 2'b11
  } dem_mode_e;

  localparam int N_ELEM_DEF = 3;

  // Level code must represent 0..n inclusive.
  function automatic int code_w_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bioz_afe_dtbpsdm_dwa_rotate.sv
// Combinational rotated thermometer: 'code' consecutive ones starting at
// element 'ptr', wrapping modulo N_ELEM.
module bioz_afe_dtbpsdm_dwa_rotate #(
  parameter int N_ELEM = 3,
  parameter int CODE_W = 2,
  parameter int PTR_W  = 2
) (
  input  logic [CODE_W-1:0] code,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_ELEM-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      int off;
      off = i - int'(ptr);
      if (off < 0) off = off + N_ELEM;
      sel[i] = (off < int'(code));
    end
  end

endmodule

// File: rtl/bioz_afe_dtbpsdm_dwa_controller.sv
// Data-weighted-averaging controller for the unit DAC elements: bypass,
// lowpass rotation and bandpass interleaved rotation with sticky error flag.
module bioz_afe_dtbpsdm_dwa_controller
  import bioz_afe_dtbpsdm_dwa_controller_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int CODE_W = code_w_f(N_ELEM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              ptr_clr,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic [N_ELEM-1:0] elem_sel,
  output logic              elem_valid,
  output logic              err
);

  localparam int PTR_W = $clog2(N_ELEM);

  function automatic logic code_over(input logic [CODE_W-1:0] c);
    int v;
    v = int'(c);
    return (v > N_ELEM);
  endfunction

  function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
    if (code_over(c)) return CODE_W'(N_ELEM);
    return c;
  endfunction

  // Sum is at most 2*N_ELEM-1, so one conditional subtraction is a full modulo.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input logic [CODE_W-1:0] c);
    int s;
    s = int'(p) + int'(c);
    if (s >= N_ELEM) s = s - N_ELEM;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0]  r_ptr0, r_ptr1;
  logic              r_par;
  dem_mode_e         r_last_mode;
  logic [N_ELEM-1:0] r_elem_sel_p1;
  logic              r_vld_p1;
  logic              r_err;

  dem_mode_e         w_mode_p0;
  logic              w_acc_p0;
  logic              w_clr_p0;
  logic [CODE_W-1:0] w_code_p0;
  logic              w_err_set_p0;
  logic [PTR_W-1:0]  w_ptr0_b, w_ptr1_b, w_ptr0_n, w_ptr1_n, w_rot_ptr_p0;
  logic              w_par_b, w_par_n;
  logic [N_ELEM-1:0] w_sel_p0;

  // Stage p0: accept, clear base state, select pointer and compute update
  assign w_mode_p0    = dem_mode_e'(mode);
  assign w_acc_p0     = en & code_valid;
  assign w_clr_p0     = ptr_clr | (w_acc_p0 & (w_mode_p0 != r_last_mode));
  assign w_code_p0    = sat_code(code);
  assign w_err_set_p0 = w_acc_p0 & (code_over(code) | (w_mode_p0 == RSVD));

  always_comb begin
    w_ptr0_b     = w_clr_p0 ? '0 : r_ptr0;
    w_ptr1_b     = w_clr_p0 ? '0 : r_ptr1;
    w_par_b      = w_clr_p0 ? 1'b0 : r_par;
    w_ptr0_n     = w_ptr0_b;
    w_ptr1_n     = w_ptr1_b;
    w_par_n      = w_par_b;
    w_rot_ptr_p0 = '0;
    if (w_acc_p0) begin
      case (w_mode_p0)
        LP_DWA: begin
          w_rot_ptr_p0 = w_ptr0_b;
          w_ptr0_n     = wrap_add(w_ptr0_b, w_code_p0);
        end
        BP_DWA: begin
          w_par_n = ~w_par_b;
          if (w_par_b) begin
            w_rot_ptr_p0 = w_ptr1_b;
            w_ptr1_n     = wrap_add(w_ptr1_b, w_code_p0);
          end else begin
            w_rot_ptr_p0 = w_ptr0_b;
            w_ptr0_n     = wrap_add(w_ptr0_b, w_code_p0);
          end
        end
        default: ;
      endcase
    end
  end

  bioz_afe_dtbpsdm_dwa_rotate #(
    .N_ELEM (N_ELEM),
    .CODE_W (CODE_W),
    .PTR_W  (PTR_W)
  ) u_rotate (
    .code (w_code_p0),
    .ptr  (w_rot_ptr_p0),
    .sel  (w_sel_p0)
  );

  // Stage p1: registered element drive and pointer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr0        <= '0;
      r_ptr1        <= '0;
      r_par         <= 1'b0;
      r_last_mode   <= BYPASS;
      r_elem_sel_p1 <= '0;
      r_vld_p1      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_ptr0   <= w_ptr0_n;
      r_ptr1   <= w_ptr1_n;
      r_par    <= w_par_n;
      r_vld_p1 <= w_acc_p0;
      r_err    <= r_err | w_err_set_p0;
      if (w_acc_p0) begin
        r_last_mode   <= w_mode_p0;
        r_elem_sel_p1 <= w_sel_p0;
      end
    end
  end

  assign elem_sel   = r_elem_sel_p1;
  assign elem_valid = r_vld_p1;
  assign err        = r_err;

endmodule

// File: doc/bioz_afe_dtbpsdm_dwa_controller.md
BIOZ_AFE_DTBPSDM_DWA_CONTROLLER -- requirements
Module: bioz_afe_dtbpsdm_dwa_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter N_ELEM, default 3, meaning the number of unit DAC elements (legal range 3..8).
REQ-003 The block SHALL have parameter CODE_W, default 2, meaning the level-code width; it equals clog2(N_ELEM+1).
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, block enable.
- mode, in, 2, DEM mode: 00 bypass, 01 lowpass DWA, 10 bandpass interleaved DWA, 11 reserved.
- ptr_clr, in, 1, synchronous clear of pointers and parity.
- code_valid, in, 1, strobe marking code as valid this cycle.
- code, in, CODE_W, quantizer level 0..N_ELEM, taken from the 4-to-2 encoder outp.
- elem_sel, out, N_ELEM, unit element drive (1 = +ref, 0 = -ref).
- elem_valid, out, 1, elem_sel updated this cycle.
- err, out, 1, sticky error flag.

Function
REQ-005 A sample SHALL be accepted only in a cycle where en=1 and code_valid=1.
REQ-006 For an accepted sample, elem_sel and elem_valid=1 SHALL be registered at the next rising edge, giving one cycle of latency.
REQ-007 elem_valid SHALL be 0 in every cycle that does not follow an accepted sample; elem_sel SHALL hold its value.
REQ-008 Bypass mode SHALL set elem_sel to a thermometer of code with the ones in the LSBs; pointers SHALL not change.
REQ-009 Lowpass mode SHALL set elem_sel to code consecutive ones starting at bit ptr0 and wrapping modulo N_ELEM.
- Update: ptr0 <= (ptr0+code) mod N_ELEM.
REQ-010 Bandpass mode SHALL use pointer p[par] (ptr0 when par=0, ptr1 when par=1) with the rotation rule of REQ-009.
- Only p[par] SHALL update.
- par SHALL toggle on every accepted sample.
REQ-011 A code of 0 SHALL give elem_sel all zeros with the pointer unchanged.
- A code of N_ELEM SHALL give all ones, and the pointer is unchanged by modulo arithmetic.
REQ-012 A code greater than N_ELEM SHALL saturate to N_ELEM and set err.
REQ-013 mode=11 SHALL behave as bypass and set err.
REQ-014 The mode SHALL be sampled per accepted sample.
- A mode value differing from the last accepted mode SHALL clear ptr0, ptr1 and par before that sample is processed.
REQ-015 ptr_clr=1 SHALL clear ptr0, ptr1 and par at the edge.
- If a sample is also accepted in that cycle, it SHALL use pointer 0 and par 0, then update from that state.
REQ-016 err SHALL clear only on reset.
REQ-017 Pointer arithmetic SHALL use width clog2(N_ELEM) with explicit modulo; no out-of-range pointer value SHALL ever be stored.

Reset
REQ-018 While rst_n=0, the block SHALL hold these values:
- elem_sel = 0, elem_valid = 0, err = 0.
- ptr0 = 0, ptr1 = 0, par = 0.
- last mode = bypass.
REQ-019 Reset asserted mid-stream SHALL discard any in-flight sample; no elem_valid SHALL follow reset release without a new accepted sample.

Structure
REQ-020 A shared package SHALL hold:
- the DEM mode enum (BYPASS, LP_DWA, BP_DWA, RSVD);
- the N_ELEM default;
- the CODE_W derivation function.
REQ-021 The combinational rotate-thermometer SHALL be one sub-module, bioz_afe_dtbpsdm_dwa_rotate, with inputs code and ptr and output sel.

Verification
REQ-022 Lowpass scenario: after reset, codes 1,1,1 -> elem_sel 001, 010, 100; ptr0 ends at 0; each output is one cycle after its strobe.
REQ-023 Lowpass wrap scenario: with ptr0=2, code 2 -> elem_sel 101, ptr0=1; then code 3 -> elem_sel 111, ptr0=1.
REQ-024 Bandpass scenario: after reset, codes 1,1,1,1 -> elem_sel 001, 001, 010, 010; final ptr0=2, ptr1=2.
REQ-025 Bypass and error scenario:
- Bypass, code 2 repeated -> elem_sel 011 every time, pointers stay 0.
- mode=11 -> err=1, and err stays 1 after mode returns to 00.
REQ-026 Mode-change, clear and reset scenario:
- Lowpass with ptr0=2, switch to bandpass with code 1 -> elem_sel 001.
- ptr_clr and code_valid in the same cycle with code 2 -> elem_sel 011.
- rst_n pulsed low between a strobe and its output -> elem_valid stays 0.
